// File: rtl/mx_elem_align.sv
// mx_elem_align: aligns each element's mantissa to the block's shared exponent and emits MX integers
module mx_elem_align #(
   parameter int width     = 8,
   parameter int man_width = 7,
   parameter int length    = 32,
   parameter int out_width = 8
) (
   input  logic                             i_clk,
   input  logic                             i_rst_n,
   input  logic                             i_valid,
   output logic                             o_ready,
   input  logic [length-1:0]                i_signs,
   input  logic [length-1:0][width-1:0]     i_exps,
   input  logic [length-1:0][man_width-1:0] i_mans,
   input  logic [width-1:0]                 i_e_max,
   output logic                             o_valid,
   input  logic                             i_ready,
   output logic [length-1:0][out_width-1:0] o_elems,
   output logic [width-1:0]                 o_scale,
   output logic                             o_err
);
   localparam int M = out_width - 1;
   localparam logic [width-1:0] m_lim = width'(M);

   logic                             s1_valid_q, s1_valid_d;
   logic [length-1:0]                s1_sign_q, s1_sign_d;
   logic [length-1:0][M-1:0]         s1_sig_q, s1_sig_d;
   logic [length-1:0][width-1:0]     s1_shift_q, s1_shift_d;
   logic [width-1:0]                 s1_emax_q, s1_emax_d;
   logic                             s1_err_q, s1_err_d;
   logic                             s2_valid_q, s2_valid_d;
   logic [length-1:0][out_width-1:0] s2_elems_q, s2_elems_d;
   logic [width-1:0]                 s2_scale_q, s2_scale_d;
   logic                             s2_err_q, s2_err_d;
   logic                             s2_load, accept;
   logic [man_width:0]               full;
   logic                             over;
   logic [M-1:0]                     mag;

   assign s2_load = !s2_valid_q || i_ready;
   assign o_ready = !s1_valid_q || s2_load;
   assign accept  = i_valid && o_ready;
   assign o_valid = s2_valid_q;
   assign o_elems = s2_elems_q;
   assign o_scale = s2_scale_q;
   assign o_err   = s2_err_q;

   // stage 1: per-element significand (top M bits), clamped shift distance and block error flag
   always_comb begin
      s1_sign_d  = s1_sign_q;
      s1_sig_d   = s1_sig_q;
      s1_shift_d = s1_shift_q;
      s1_emax_d  = s1_emax_q;
      s1_err_d   = s1_err_q;
      full       = '0;
      over       = 1'b0;
      if (accept) begin
         s1_sign_d = i_signs;
         s1_emax_d = i_e_max;
         s1_err_d  = 1'b0;
         for (int k = 0; k < length; k++) begin
            full          = (i_exps[k] == '0) ? '0 : {1'b1, i_mans[k]};
            over          = i_exps[k] > i_e_max;
            s1_err_d      = s1_err_d | over;
            s1_shift_d[k] = over ? '0 : i_e_max - i_exps[k];
            s1_sig_d[k]   = (s1_shift_d[k] >= m_lim) ? '0 : M'(full >> (man_width + 1 - M));
         end
      end
      s1_valid_d = accept ? 1'b1 : (s2_load ? 1'b0 : s1_valid_q);
   end

   // stage 2: truncating right shift and sign application into two's complement
   always_comb begin
      s2_elems_d = s2_elems_q;
      s2_scale_d = s2_scale_q;
      s2_err_d   = s2_err_q;
      mag        = '0;
      if (s2_load && s1_valid_q) begin
         s2_scale_d = s1_emax_q;
         s2_err_d   = s1_err_q;
         for (int k = 0; k < length; k++) begin
            mag           = s1_sig_q[k] >> s1_shift_q[k];
            s2_elems_d[k] = s1_sign_q[k] ? -{1'b0, mag} : {1'b0, mag};
         end
      end
      s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
   end

   // pipeline registers; reset discards anything in flight
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_valid_q <= 1'b0;
         s1_sign_q  <= '0;
         s1_sig_q   <= '0;
         s1_shift_q <= '0;
         s1_emax_q  <= '0;
         s1_err_q   <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_elems_q <= '0;
         s2_scale_q <= '0;
         s2_err_q   <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_sign_q  <= s1_sign_d;
         s1_sig_q   <= s1_sig_d;
         s1_shift_q <= s1_shift_d;
         s1_emax_q  <= s1_emax_d;
         s1_err_q   <= s1_err_d;
         s2_valid_q <= s2_valid_d;
         s2_elems_q <= s2_elems_d;
         s2_scale_q <= s2_scale_d;
         s2_err_q   <= s2_err_d;
      end
   end
endmodule

// File: tb/tb_mx_elem_align.sv
// tb_mx_elem_align: scoreboard bench for the MX element alignment pipeline
module tb_mx_elem_align;
   localparam int W  = 8;
   localparam int MW = 7;
   localparam int L  = 32;
   localparam int OW = 8;
   localparam int M  = OW - 1;

   typedef struct {
      logic [L-1:0][OW-1:0] elems;
      logic [W-1:0]         scale;
      logic                 err;
   } exp_t;

   logic                 clk, rst_n, i_valid, o_ready, o_valid, i_ready, o_err;
   logic [L-1:0]         i_signs;
   logic [L-1:0][W-1:0]  i_exps;
   logic [L-1:0][MW-1:0] i_mans;
   logic [W-1:0]         i_e_max, o_scale;
   logic [L-1:0][OW-1:0] o_elems;

   logic [L-1:0]         cur_signs;
   logic [L-1:0][W-1:0]  cur_exps;
   logic [L-1:0][MW-1:0] cur_mans;
   logic [W-1:0]         cur_emax;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   bit   rand_rdy = 0;

   mx_elem_align dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_signs(i_signs), .i_exps(i_exps), .i_mans(i_mans), .i_e_max(i_e_max),
      .o_valid(o_valid), .i_ready(i_ready), .o_elems(o_elems), .o_scale(o_scale), .o_err(o_err)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   // reference: real-valued alignment by integer division, sign applied afterwards
   function automatic exp_t model(input logic [L-1:0] s, input logic [L-1:0][W-1:0] e,
                                  input logic [L-1:0][MW-1:0] m, input logic [W-1:0] emax);
      exp_t r;
      int sig, sh, mg;
      r.err   = 1'b0;
      r.scale = emax;
      for (int k = 0; k < L; k++) begin
         if (int'(e[k]) > int'(emax)) begin
            r.err = 1'b1;
            sh    = 0;
         end else sh = int'(emax) - int'(e[k]);
         sig = (e[k] == 0) ? 0 : ((2 ** MW) + int'(m[k])) / (2 ** (MW + 1 - M));
         mg  = (sh >= M) ? 0 : sig / (2 ** sh);
         r.elems[k] = OW'(s[k] ? -mg : mg);
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_blk();
      cur_signs = '0;
      cur_exps  = '0;
      cur_mans  = '0;
   endtask

   task automatic gen_random();
      int x;
      cur_emax = W'($urandom_range(1, 254));
      for (int k = 0; k < L; k++) begin
         cur_signs[k] = 1'($urandom_range(0, 1));
         cur_mans[k]  = MW'($urandom);
         x = int'(cur_emax) - int'($urandom_range(0, 9));
         cur_exps[k]  = ($urandom_range(0, 12) == 0 || x < 0) ? '0 : W'(x);
      end
      if ($urandom_range(0, 3) == 0) cur_exps[$urandom_range(0, L - 1)] = cur_emax + 1'b1;
   endtask

   // offer the current block until accepted; push its expectation at the accepting edge
   task automatic offer();
      i_signs = cur_signs;
      i_exps  = cur_exps;
      i_mans  = cur_mans;
      i_e_max = cur_emax;
      i_valid = 1'b1;
      for (int c = 0; c < 200; c++) begin
         if (rand_rdy) i_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (o_ready) begin
            sb.push_back(model(cur_signs, cur_exps, cur_mans, cur_emax));
            @(posedge clk);
            #1 i_valid = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      checks++;
      errors++;
      $display("FAIL accept_timeout: o_ready never rose");
      i_valid = 1'b0;
   endtask

   task automatic wait_out();
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (o_valid) return;
      end
      checks++;
      errors++;
      $display("FAIL output_timeout: o_valid never rose");
   endtask

   task automatic drain();
      for (int c = 0; c < 200 && sb.size() != 0; c++) @(posedge clk);
      chk("drain_empty", 512'(sb.size()), 512'(0));
      #1;
   endtask

   // monitor: compares each consumed block in order and checks that stalled outputs hold
   initial begin
      exp_t e;
      bit stall = 0;
      logic [L-1:0][OW-1:0] pe;
      logic [W-1:0] ps;
      logic perr;
      forever begin
         @(negedge clk);
         if (!rst_n) stall = 0;
         else begin
            if (stall) begin
               checks++;
               if (!o_valid || o_elems !== pe || o_scale !== ps || o_err !== perr) begin
                  errors++;
                  $display("FAIL stall_hold: got v=%0b scale=%0h err=%0b expected v=1 scale=%0h err=%0b held",
                           o_valid, o_scale, o_err, ps, perr);
               end
            end
            stall = o_valid && !i_ready;
            pe = o_elems;
            ps = o_scale;
            perr = o_err;
            if (o_valid && i_ready) begin
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_output: got block scale=%0h expected no output", o_scale);
               end else begin
                  e = sb.pop_front();
                  if (o_elems !== e.elems || o_scale !== e.scale || o_err !== e.err) begin
                     errors++;
                     $display("FAIL block_out: got scale=%0h err=%0b elems=%0h expected scale=%0h err=%0b elems=%0h",
                              o_scale, o_err, o_elems, e.scale, e.err, e.elems);
                  end
               end
            end
         end
      end
   end

   initial begin
      exp_t a;
      rst_n = 0; i_valid = 0; i_ready = 1;
      i_signs = '0; i_exps = '0; i_mans = '0; i_e_max = '0;
      clear_blk();
      cur_emax = '0;
      repeat (2) @(negedge clk);
      chk("rst_valid", 512'(o_valid), 512'(0));
      chk("rst_elems", 512'(o_elems), 512'(0));
      chk("rst_scale", 512'(o_scale), 512'(0));
      chk("rst_err", 512'(o_err), 512'(0));
      rst_n = 1;
      @(posedge clk);
      #1 chk("rst_ready", 512'(o_ready), 512'(1));

      // directed alignment with latency check
      clear_blk();
      cur_emax = 8'd130;
      cur_exps[0] = 8'd130; cur_mans[0] = 7'h40;
      cur_signs[1] = 1'b1; cur_exps[1] = 8'd128; cur_mans[1] = 7'h40;
      cur_exps[2] = 8'd120; cur_mans[2] = 7'h55;
      cur_exps[3] = 8'd0;   cur_mans[3] = 7'h7F;
      offer();
      @(negedge clk);
      chk("lat_not_yet", 512'(o_valid), 512'(0));
      @(negedge clk);
      chk("lat_valid", 512'(o_valid), 512'(1));
      chk("elem0", 512'(o_elems[0]), 512'(96));
      chk("elem1", 512'(o_elems[1]), 512'(8'hE8));
      chk("elem2", 512'(o_elems[2]), 512'(0));
      chk("elem3", 512'(o_elems[3]), 512'(0));
      chk("scale", 512'(o_scale), 512'(130));
      chk("err_clean", 512'(o_err), 512'(0));
      @(posedge clk);
      #1;

      // exponent above the shared max flags the block
      cur_exps[4] = 8'd131; cur_mans[4] = 7'h40;
      offer();
      wait_out();
      chk("err_set", 512'(o_err), 512'(1));
      chk("elem4_over", 512'(o_elems[4]), 512'(96));
      @(posedge clk);
      #1 cur_exps[4] = 8'd129;
      offer();
      wait_out();
      chk("err_cleared", 512'(o_err), 512'(0));
      chk("elem4_half", 512'(o_elems[4]), 512'(48));
      @(posedge clk);
      #1;

      // stall: A and B fill the pipe, C is refused until the sink is ready
      i_ready = 0;
      gen_random();
      a = model(cur_signs, cur_exps, cur_mans, cur_emax);
      offer();
      gen_random();
      offer();
      gen_random();
      i_signs = cur_signs; i_exps = cur_exps; i_mans = cur_mans; i_e_max = cur_emax;
      i_valid = 1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("stall_ready", 512'(o_ready), 512'(0));
         chk("stall_elems_a", 512'(o_elems), 512'(a.elems));
         @(posedge clk);
         #1;
      end
      i_ready = 1;
      offer();
      drain();

      // random back-to-back traffic with a randomly stalling sink
      rand_rdy = 1;
      for (int b = 0; b < 10; b++) begin
         gen_random();
         offer();
      end
      rand_rdy = 0;
      i_ready = 1;
      drain();

      // reset with both stages full discards everything
      i_ready = 0;
      gen_random();
      offer();
      gen_random();
      offer();
      #2 rst_n = 0;
      #1 chk("midrst_valid", 512'(o_valid), 512'(0));
      sb.delete();
      @(negedge clk);
      rst_n = 1;
      i_ready = 1;
      #1 chk("midrst_ready", 512'(o_ready), 512'(1));
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("midrst_no_stale", 512'(o_valid), 512'(0));
      end
      @(posedge clk);
      #1 gen_random();
      offer();
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
